delay_prog_mfic: RTL
====================

# delay_prog_mfic

Runtime-programmable multichannel sample delay line with a valid-strobe interface. CH channels of W bits share one strobe and a circular buffer of DMAX samples. The delay in strobes is loaded at run time and clamped to 1..DMAX. The block sits in the MFIC datapath wherever a fixed register-chain delay is too rigid: variable alignment of filter branches, and gated or decimated sample streams.

## Interface
- W, 16, sample width per channel
- CH, 1, number of channels; all channels share strobe and delay
- DMAX, 16, maximum delay in strobes and buffer depth; ≥2, need not be a power of two
- DEF_DELAY, 10, delay after reset; 1..DMAX
- DW = $clog2(DMAX+1), derived width of the delay port
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- din_valid  in  1  input sample strobe
- din  in  CH*W  channel samples; channel c at [c*W +: W]
- delay  in  DW  requested delay in strobes
- delay_ld  in  1  load pulse for delay
- dout  out  CH*W  delayed samples; reset value 0
- dout_valid  out  1  output strobe; reset value 0

## Operation
- Time advances only on strobes (din_valid=1). Idle cycles change nothing except delay loading.
- Delay register delay_q:
  - Reset value is DEF_DELAY.
  - When delay_ld=1, delay_q is updated with clamp(delay): 0 becomes 1, values above DMAX become DMAX.
- Write pointer wr_ptr:
  - Reset value is 0.
  - On each strobe, din is written at wr_ptr, then wr_ptr advances, wrapping from DMAX-1 to 0.
- Read address: (wr_ptr − delay_q) mod DMAX, computed without requiring a power-of-two DMAX.
  - Each read returns the content before that cycle's write (read-before-write).
  - So delay_q=DMAX reads the slot being overwritten.
- Fill counter fill:
  - Counts strobes since reset and saturates at DMAX.
  - It is not cleared when the delay changes. Buffer contents stay genuine history, so a new delay is valid at once if fill ≥ new delay.
- Output on strobe k, where k counts strobes since reset starting at 0:
  - If fill ≥ delay_q before the strobe: dout = din of strobe k−delay_q, and dout_valid pulses.
  - Otherwise: behaviour is set by the Configuration section.
- Delay change: the new delay takes effect on the first strobe after the cycle in which it is loaded.
- dout holds its last value between strobes. dout_valid is high for exactly one cycle per qualifying strobe.
- Buffer memory is not reset; it may map to RAM. Unfilled slots are never emitted as data.
- Reset asserted mid-stream: on the next edge all registers return to reset values. Any output in flight is lost and filling restarts.

## Timing
- Latency: dout and dout_valid are registered and appear 1 clk after the strobe edge.
- Throughput: one strobe per clk with no bubbles.
- Strobe and delay_ld in the same cycle: that strobe uses the old delay_q.
- Consecutive loads without a strobe in between: the last load wins.
- Wrap-around of wr_ptr and of the read address must be seamless for every delay_q and every DMAX.

## Configuration
- DLY_ZERO_FILL_EN defined:
  - Every strobe produces dout_valid one cycle later.
  - While fill < delay_q, dout is all zeros. This gives a stream of constant rate from the first sample.
- DLY_ZERO_FILL_EN undefined:
  - Strobes with fill < delay_q produce no dout_valid.
  - dout keeps its previous value.

## Structure
- Package delay_mfic_pkg holds:
  - clamp function for delay values
  - modular pointer-subtract function
  - DW width helper
- Sub-module delay_mfic_ram: simple dual-port, CH*W wide, DMAX deep, read-before-write, synchronous read, no reset.
- The top level holds pointer, fill counter, delay register and output logic.

## Test plan
- Reset behaviour: DEF_DELAY=10, DMAX=16, ramp din=1,2,3… on every clk → first dout_valid on strobe 10 with dout=1. Thereafter dout = din−10, one cycle after each strobe.
- Gated strobes: din_valid on 1 cycle in 3, delay 4 → output follows the strobe count, not the clk count. Idle cycles are ignored and dout holds.
- Extremes: delay_ld with delay=0, then with delay=DMAX, then with delay=31 → effective delays 1, 16 and 16. At 16, dout = din of 16 strobes earlier across several wraps.
- Delay change mid-stream: after 20 strobes at delay 10, load 3 → next strobe outputs the sample 3 back with no gap. Then load 16 → valid immediately, because fill=16.
- Reset mid-stream: assert reset for 1 cycle after 7 strobes → dout=0 and dout_valid=0. Refill restarts, and the first valid output comes after DEF_DELAY strobes.
- Zero fill, CH=2: with DLY_ZERO_FILL_EN defined and delay 5 → first 5 strobes give dout=0 with dout_valid. Both channels stay independent and correctly delayed.

Source files
------------

// File: rtl/delay_mfic_pkg.sv
// rtl/delay_mfic_pkg.sv - shared helpers for the programmable delay line
package delay_mfic_pkg;

  function automatic int unsigned dw_of(input int unsigned dmax);
    return $clog2(dmax + 1);
  endfunction

  function automatic int unsigned clamp_delay(input int unsigned d, input int unsigned dmax);
    if (d == 0) return 1;
    if (d > dmax) return dmax;
    return d;
  endfunction

  // (p - d) mod dmax for p < dmax and 1 <= d <= dmax; works for any dmax
  function automatic int unsigned ptr_sub(input int unsigned p, input int unsigned d,
                                          input int unsigned dmax);
    return (p >= d) ? p - d : p + dmax - d;
  endfunction

endpackage

// File: rtl/delay_mfic_ram.sv
// rtl/delay_mfic_ram.sv - simple dual-port sample buffer, synchronous read-before-write, no reset
module delay_mfic_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Same-edge read and write: the read returns the old word
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/delay_prog_mfic.sv
// rtl/delay_prog_mfic.sv - runtime-programmable multichannel strobe-driven delay line
// DLY_ZERO_FILL_EN: emit zero samples with dout_valid while the buffer is not yet filled
module delay_prog_mfic
  import delay_mfic_pkg::*;
#(
  parameter int  W         = 16,
  parameter int  CH        = 1,
  parameter int  DMAX      = 16,
  parameter int  DEF_DELAY = 10,
  localparam int DW        = dw_of(DMAX)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            din_valid,
  input  logic [CH*W-1:0] din,
  input  logic [DW-1:0]   delay,
  input  logic            delay_ld,
  output logic [CH*W-1:0] dout,
  output logic            dout_valid
);

  localparam int AW     = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam int DATA_W = CH * W;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_addr;
  logic [DW-1:0]     delay_q, delay_d, fill_q, fill_d;
  logic              valid_q, valid_d, has_data_q, has_data_d, zero_q, zero_d;
  logic              filled, rd_en;
  logic [DATA_W-1:0] rd_data;

  assign filled  = (fill_q >= delay_q);
  assign rd_addr = AW'(ptr_sub(32'(wr_ptr_q), 32'(delay_q), unsigned'(DMAX)));

`ifdef DLY_ZERO_FILL_EN
  assign rd_en = din_valid;
`else
  assign rd_en = din_valid & filled;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    delay_d    = delay_q;
    valid_d    = 1'b0;
    has_data_d = has_data_q;
    zero_d     = zero_q;
    if (din_valid) begin
      wr_ptr_d = (wr_ptr_q == AW'(DMAX - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (fill_q != DW'(DMAX)) fill_d = fill_q + 1'b1;
      if (filled) begin
        valid_d    = 1'b1;
        has_data_d = 1'b1;
        zero_d     = 1'b0;
      end else begin
`ifdef DLY_ZERO_FILL_EN
        valid_d = 1'b1;
        zero_d  = 1'b1;
`else
        valid_d = 1'b0;
`endif
      end
    end
    // A strobe in the load cycle has already used the old delay above
    if (delay_ld) delay_d = DW'(clamp_delay(32'(delay), unsigned'(DMAX)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      delay_q    <= DW'(DEF_DELAY);
      valid_q    <= 1'b0;
      has_data_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      delay_q    <= delay_d;
      valid_q    <= valid_d;
      has_data_q <= has_data_d;
      zero_q     <= zero_d;
    end
  end

  delay_mfic_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DMAX),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (din_valid),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // The RAM word is uninitialised until the first genuine read, so gate it
  assign dout       = (has_data_q && !zero_q) ? rd_data : '0;
  assign dout_valid = valid_q;

endmodule
